// File: rtl/rv32i_types.sv
// Shared RV32I load/store types: queue entry layout, LSQ FSM states and funct3 width codes.
package rv32i_types;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Tags are stored at a fixed maximum width so the entry type is parameter-independent.
  localparam int LSQ_TAG_MAX_W = 16;
  typedef logic [LSQ_TAG_MAX_W-1:0] lsq_tag_t;

  typedef enum logic [1:0] {
    LSQ_IDLE   = 2'd0,
    LSQ_ACCESS = 2'd1,
    LSQ_DRAIN  = 2'd2
  } lsq_state_e;

  typedef struct packed {
    logic        valid;
    logic        is_store;
    lsq_tag_t    tag;
    logic [2:0]  funct3;
    logic [31:0] imm;
    logic        s1_rdy;
    lsq_tag_t    s1_tag;
    logic [31:0] s1;
    logic        s2_rdy;
    lsq_tag_t    s2_tag;
    logic [31:0] s2;
  } lsq_entry_t;

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
    return ((f3[1:0] == 2'b01) && a[0]) || ((f3[1:0] == 2'b10) && (a != 2'b00));
  endfunction

endpackage

// File: rtl/lsq_lane_align.sv
// Combinational byte-lane steering: load extract/extend, store shift and byte-enable generation.
module lsq_lane_align
  import rv32i_types::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] load_word,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic [31:0] store_word,
  output logic [3:0]  byte_enable
);

  logic [31:0] shifted;

  always_comb begin
    shifted = load_word >> {offset, 3'b000};
    case (funct3)
      F3_LB:   load_data = {{24{shifted[7]}}, shifted[7:0]};
      F3_LBU:  load_data = {24'b0, shifted[7:0]};
      F3_LH:   load_data = {{16{shifted[15]}}, shifted[15:0]};
      F3_LHU:  load_data = {16'b0, shifted[15:0]};
      F3_LW:   load_data = load_word;
      default: load_data = load_word;
    endcase
  end

  always_comb begin
    store_word = store_data << {offset, 3'b000};
    case (funct3[1:0])
      2'b00:   byte_enable = 4'b0001 << offset;
      2'b01:   byte_enable = 4'b0011 << {offset[1], 1'b0};
      2'b10:   byte_enable = 4'b1111;
      default: byte_enable = 4'b0000;
    endcase
  end

endmodule

// File: rtl/lsq_ordered.sv
// Program-ordered unified load/store queue: CDB operand capture, single in-order access from the head.
module lsq_ordered
  import rv32i_types::*;
#(
  parameter int DEPTH   = 8,
  parameter int TAG_W   = 5,
  parameter int NUM_CDB = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     enq_valid,
  output logic                     enq_ready,
  input  logic                     enq_is_store,
  input  logic [TAG_W-1:0]         enq_tag,
  input  logic [2:0]               enq_funct3,
  input  logic [31:0]              enq_imm,
  input  logic                     enq_s1_rdy,
  input  logic                     enq_s2_rdy,
  input  logic [TAG_W-1:0]         enq_s1_tag,
  input  logic [TAG_W-1:0]         enq_s2_tag,
  input  logic [31:0]              enq_s1,
  input  logic [31:0]              enq_s2,
  input  logic [NUM_CDB-1:0]       cdb_valid,
  input  logic [NUM_CDB*TAG_W-1:0] cdb_tag,
  input  logic [NUM_CDB*32-1:0]    cdb_data,
  input  logic                     store_ready,
  input  logic                     load_ready,
  output logic                     mem_read,
  output logic                     mem_write,
  output logic [31:0]              mem_addr,
  output logic [31:0]              mem_wdata,
  output logic [3:0]               mem_byte_enable,
  input  logic [31:0]              mem_rdata,
  input  logic                     mem_resp,
  output logic                     res_valid,
  output logic [TAG_W-1:0]         res_tag,
  output logic [31:0]              res_data,
  output logic                     res_misalign,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  lsq_entry_t      ent_q [DEPTH];
  lsq_entry_t      ent_d [DEPTH];
  lsq_entry_t      enq_entry;
  logic [PW-1:0]   head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  lsq_state_e      state_q;
  logic            mem_read_q, mem_write_q, res_valid_q, res_mis_q;
  logic [31:0]     mem_addr_q, mem_wdata_q, res_data_q;
  logic [3:0]      mem_be_q;
  logic [TAG_W-1:0] res_tag_q;

  function automatic lsq_tag_t widen(input logic [TAG_W-1:0] t);
    lsq_tag_t w;
    w = '0;
    w[TAG_W-1:0] = t;
    return w;
  endfunction

  // Scanning from the top lane down leaves the lowest matching lane as the winner.
  function automatic logic [32:0] snoop(input lsq_tag_t t);
    logic [32:0] r;
    r = '0;
    for (int i = NUM_CDB - 1; i >= 0; i--) begin
      if (cdb_valid[i] && (widen(cdb_tag[i*TAG_W +: TAG_W]) == t)) r = {1'b1, cdb_data[i*32 +: 32]};
    end
    return r;
  endfunction

  logic [32:0] s1_hit [DEPTH];
  logic [32:0] s2_hit [DEPTH];
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_snoop
    assign s1_hit[gi] = snoop(ent_q[gi].s1_tag);
    assign s2_hit[gi] = snoop(ent_q[gi].s2_tag);
  end

  logic [31:0] head_addr, ld_data, st_word;
  logic [3:0]  st_be;
  logic        head_elig, head_mis, idle_go, retire_mis, issue_ld, issue_st;
  logic        access_done, deq, enq_acc;

  assign head_addr  = ent_q[head_q].s1 + ent_q[head_q].imm;
  assign head_elig  = ent_q[head_q].valid && ent_q[head_q].s1_rdy &&
                      (!ent_q[head_q].is_store || ent_q[head_q].s2_rdy);
  assign head_mis   = is_misaligned(ent_q[head_q].funct3, head_addr[1:0]);
  assign idle_go    = (state_q == LSQ_IDLE) && head_elig && !flush;
  assign retire_mis = idle_go && head_mis;
  assign issue_ld   = idle_go && !head_mis && !ent_q[head_q].is_store && load_ready;
  assign issue_st   = idle_go && !head_mis && ent_q[head_q].is_store && store_ready;
  assign access_done = (state_q == LSQ_ACCESS) && mem_resp && !flush;
  assign deq        = retire_mis || access_done;
  assign enq_ready  = (count_q < CW'(DEPTH)) && (state_q != LSQ_DRAIN);
  assign enq_acc    = enq_valid && enq_ready && !flush;

  lsq_lane_align u_align (
    .funct3      (ent_q[head_q].funct3),
    .offset      (head_addr[1:0]),
    .load_word   (mem_rdata),
    .store_data  (ent_q[head_q].s2),
    .load_data   (ld_data),
    .store_word  (st_word),
    .byte_enable (st_be)
  );

  always_comb begin
    logic [32:0] h1, h2;
    h1 = snoop(widen(enq_s1_tag));
    h2 = snoop(widen(enq_s2_tag));
    enq_entry          = '0;
    enq_entry.valid    = 1'b1;
    enq_entry.is_store = enq_is_store;
    enq_entry.tag      = widen(enq_tag);
    enq_entry.funct3   = enq_funct3;
    enq_entry.imm      = enq_imm;
    enq_entry.s1_tag   = widen(enq_s1_tag);
    enq_entry.s2_tag   = widen(enq_s2_tag);
    enq_entry.s1_rdy   = enq_s1_rdy || h1[32];
    enq_entry.s1       = enq_s1_rdy ? enq_s1 : h1[31:0];
    enq_entry.s2_rdy   = enq_s2_rdy || h2[32];
    enq_entry.s2       = enq_s2_rdy ? enq_s2 : h2[31:0];
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i] = ent_q[i];
      if (!ent_q[i].s1_rdy && s1_hit[i][32]) begin
        ent_d[i].s1_rdy = 1'b1;
        ent_d[i].s1     = s1_hit[i][31:0];
      end
      if (!ent_q[i].s2_rdy && s2_hit[i][32]) begin
        ent_d[i].s2_rdy = 1'b1;
        ent_d[i].s2     = s2_hit[i][31:0];
      end
      if (deq && (head_q == PW'(i))) ent_d[i].valid = 1'b0;
      if (enq_acc && (tail_q == PW'(i))) ent_d[i] = enq_entry;
      if (flush) ent_d[i].valid = 1'b0;
    end
  end

  always_comb begin
    head_d  = head_q + PW'(deq);
    tail_d  = tail_q + PW'(enq_acc);
    count_d = count_q + CW'(enq_acc) - CW'(deq);
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // The head entry stays put during ACCESS, so it still supplies lane/sign info at response time.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= LSQ_IDLE;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      res_valid_q <= 1'b0;
      res_mis_q   <= 1'b0;
      res_tag_q   <= '0;
      res_data_q  <= '0;
    end else begin
      res_valid_q <= 1'b0;
      case (state_q)
        LSQ_IDLE: begin
          if (retire_mis) begin
            res_valid_q <= 1'b1;
            res_mis_q   <= 1'b1;
            res_tag_q   <= ent_q[head_q].tag[TAG_W-1:0];
            res_data_q  <= head_addr;
          end else if (issue_ld || issue_st) begin
            state_q     <= LSQ_ACCESS;
            mem_read_q  <= issue_ld;
            mem_write_q <= issue_st;
            mem_addr_q  <= {head_addr[31:2], 2'b00};
            mem_wdata_q <= issue_st ? st_word : 32'h0;
            mem_be_q    <= issue_st ? st_be : 4'h0;
          end
        end
        LSQ_ACCESS: begin
          if (mem_resp) begin
            state_q     <= LSQ_IDLE;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            if (!flush && !ent_q[head_q].is_store) begin
              res_valid_q <= 1'b1;
              res_mis_q   <= 1'b0;
              res_tag_q   <= ent_q[head_q].tag[TAG_W-1:0];
              res_data_q  <= ld_data;
            end
          end else if (flush) begin
            state_q <= LSQ_DRAIN;
          end
        end
        LSQ_DRAIN: begin
          if (mem_resp) begin
            state_q     <= LSQ_IDLE;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
          end
        end
        default: state_q <= LSQ_IDLE;
      endcase
    end
  end

  assign mem_read        = mem_read_q;
  assign mem_write       = mem_write_q;
  assign mem_addr        = mem_addr_q;
  assign mem_wdata       = mem_wdata_q;
  assign mem_byte_enable = mem_be_q;
  assign res_valid       = res_valid_q;
  assign res_tag         = res_tag_q;
  assign res_data        = res_data_q;
  assign res_misalign    = res_mis_q;
  assign count           = count_q;

endmodule

// File: tb/tb_lsq_ordered.sv
// Directed bench for lsq_ordered: a vector table of single accesses plus hand-written corner sequences.
module tb_lsq_ordered;

  localparam int DEPTH = 8;
  localparam int TAG_W = 5;
  localparam int NCDB  = 3;

  localparam logic [2:0] FB = 3'b000, FH = 3'b001, FW = 3'b010, FBU = 3'b100, FHU = 3'b101;

  logic clk, rst, flush;
  logic enq_valid, enq_ready, enq_is_store, enq_s1_rdy, enq_s2_rdy;
  logic [TAG_W-1:0] enq_tag, enq_s1_tag, enq_s2_tag;
  logic [2:0] enq_funct3;
  logic [31:0] enq_imm, enq_s1, enq_s2;
  logic [NCDB-1:0] cdb_valid;
  logic [NCDB*TAG_W-1:0] cdb_tag;
  logic [NCDB*32-1:0] cdb_data;
  logic store_ready, load_ready, mem_read, mem_write, mem_resp;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, res_data;
  logic [3:0] mem_byte_enable;
  logic res_valid, res_misalign;
  logic [TAG_W-1:0] res_tag;
  logic [$clog2(DEPTH):0] count;

  lsq_ordered #(.DEPTH(DEPTH), .TAG_W(TAG_W), .NUM_CDB(NCDB)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_is_store(enq_is_store),
    .enq_tag(enq_tag), .enq_funct3(enq_funct3), .enq_imm(enq_imm),
    .enq_s1_rdy(enq_s1_rdy), .enq_s2_rdy(enq_s2_rdy),
    .enq_s1_tag(enq_s1_tag), .enq_s2_tag(enq_s2_tag),
    .enq_s1(enq_s1), .enq_s2(enq_s2),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .store_ready(store_ready), .load_ready(load_ready),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .res_valid(res_valid), .res_tag(res_tag), .res_data(res_data),
    .res_misalign(res_misalign), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] base, imm, sdata, rdata;
    int          hold, waitc;
    logic        mis;
    logic [31:0] addr, wdata;
    logic [3:0]  be;
    logic [31:0] res;
  } vec_t;

  function automatic vec_t mkv(input logic st, input logic [2:0] f3, input logic [31:0] base,
                               input logic [31:0] imm, input logic [31:0] sdata, input logic [31:0] rdata,
                               input int hold, input int waitc, input logic mis, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] be, input logic [31:0] res);
    vec_t v;
    v.st = st; v.f3 = f3; v.base = base; v.imm = imm; v.sdata = sdata; v.rdata = rdata;
    v.hold = hold; v.waitc = waitc; v.mis = mis; v.addr = addr; v.wdata = wdata; v.be = be; v.res = res;
    return v;
  endfunction

  task automatic enq(input logic st, input logic [2:0] f3, input logic [4:0] tg, input logic [31:0] imm,
                     input logic r1, input logic [4:0] t1, input logic [31:0] s1,
                     input logic r2, input logic [4:0] t2, input logic [31:0] s2);
    enq_valid = 1'b1; enq_is_store = st; enq_funct3 = f3; enq_tag = tg; enq_imm = imm;
    enq_s1_rdy = r1; enq_s1_tag = t1; enq_s1 = s1;
    enq_s2_rdy = r2; enq_s2_tag = t2; enq_s2 = s2;
    @(negedge clk);
    enq_valid = 1'b0;
  endtask

  task automatic wait_req(input string name, output bit ok);
    int n;
    n = 0;
    while (!(mem_read || mem_write) && n < 20) begin
      @(negedge clk);
      n++;
    end
    ok = mem_read || mem_write;
    if (!ok) begin
      n_total++;
      $display("FAIL %s: no request after %0d cycles, required one", name, n);
    end
  endtask

  task automatic respond_load(input string name, input logic [31:0] rd, input logic [4:0] tg,
                              input logic [31:0] exp);
    mem_resp = 1'b1; mem_rdata = rd;
    @(negedge clk);
    mem_resp = 1'b0;
    check({name, "_req_drop"}, 32'(mem_read), 32'd0);
    check({name, "_res_valid"}, 32'(res_valid), 32'd1);
    check({name, "_res_tag"}, 32'(res_tag), 32'(tg));
    check({name, "_res_data"}, res_data, exp);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    logic [4:0] tg;
    tg = 5'(idx + 1);
    load_ready = (v.hold == 0); store_ready = (v.hold == 0);
    check($sformatf("v%0d_enq_ready", idx), 32'(enq_ready), 32'd1);
    enq(v.st, v.f3, tg, v.imm, 1'b1, 5'd0, v.base, 1'b1, 5'd0, v.sdata);
    for (int h = 0; h < v.hold; h++) begin
      check($sformatf("v%0d_held_req", idx), {30'b0, mem_read, mem_write}, 32'd0);
      @(negedge clk);
    end
    load_ready = 1'b1; store_ready = 1'b1;
    @(negedge clk);
    if (v.mis) begin
      check($sformatf("v%0d_mis_valid", idx), 32'(res_valid), 32'd1);
      check($sformatf("v%0d_mis_flag", idx), 32'(res_misalign), 32'd1);
      check($sformatf("v%0d_mis_tag", idx), 32'(res_tag), 32'(tg));
      check($sformatf("v%0d_mis_data", idx), res_data, v.res);
      check($sformatf("v%0d_mis_noreq", idx), {30'b0, mem_read, mem_write}, 32'd0);
      @(negedge clk);
      check($sformatf("v%0d_mis_pulse", idx), 32'(res_valid), 32'd0);
      check($sformatf("v%0d_mis_count", idx), 32'(count), 32'd0);
    end else begin
      check($sformatf("v%0d_req", idx), {30'b0, mem_read, mem_write}, {30'b0, !v.st, v.st});
      check($sformatf("v%0d_addr", idx), mem_addr, v.addr);
      if (v.st) begin
        check($sformatf("v%0d_wdata", idx), mem_wdata, v.wdata);
        check($sformatf("v%0d_be", idx), 32'(mem_byte_enable), 32'(v.be));
      end
      for (int w = 0; w < v.waitc; w++) begin
        @(negedge clk);
        check($sformatf("v%0d_hold_req", idx), {30'b0, mem_read, mem_write}, {30'b0, !v.st, v.st});
        check($sformatf("v%0d_hold_addr", idx), mem_addr, v.addr);
      end
      mem_resp = 1'b1; mem_rdata = v.rdata;
      @(negedge clk);
      mem_resp = 1'b0;
      check($sformatf("v%0d_req_drop", idx), {30'b0, mem_read, mem_write}, 32'd0);
      check($sformatf("v%0d_res_valid", idx), 32'(res_valid), 32'(!v.st));
      if (!v.st) begin
        check($sformatf("v%0d_res_data", idx), res_data, v.res);
        check($sformatf("v%0d_res_tag", idx), 32'(res_tag), 32'(tg));
        check($sformatf("v%0d_res_mis", idx), 32'(res_misalign), 32'd0);
      end
      @(negedge clk);
      check($sformatf("v%0d_pulse", idx), 32'(res_valid), 32'd0);
    end
    $display("vec %0d: st=%0d f3=%0d addr=0x%08h mis=%0d res=0x%08h", idx, v.st, v.f3,
             v.base + v.imm, v.mis, res_data);
  endtask

  vec_t vt [10];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    vt[0] = mkv(0, FW,  32'h100,      32'h4,  32'h0,        32'hDEADBEEF, 0, 3, 0, 32'h104, 32'h0,        4'h0,    32'hDEADBEEF);
    vt[1] = mkv(0, FB,  32'h200,      32'h3,  32'h0,        32'h80FF0000, 0, 0, 0, 32'h200, 32'h0,        4'h0,    32'hFFFFFF80);
    vt[2] = mkv(0, FBU, 32'h200,      32'h3,  32'h0,        32'h80FF0000, 0, 1, 0, 32'h200, 32'h0,        4'h0,    32'h00000080);
    vt[3] = mkv(1, FH,  32'h300,      32'h2,  32'h0000ABCD, 32'h0,        5, 1, 0, 32'h300, 32'hABCD0000, 4'b1100, 32'h0);
    vt[4] = mkv(0, FH,  32'h400,      32'h1,  32'h0,        32'h0,        0, 0, 1, 32'h0,   32'h0,        4'h0,    32'h401);
    vt[5] = mkv(0, FH,  32'h100,      32'h6,  32'h0,        32'h81234567, 0, 0, 0, 32'h104, 32'h0,        4'h0,    32'hFFFF8123);
    vt[6] = mkv(1, FB,  32'hFFFFFFFF, 32'h2,  32'h0000005A, 32'h0,        0, 2, 0, 32'h0,   32'h00005A00, 4'b0010, 32'h0);
    vt[7] = mkv(1, FW,  32'h500,      32'h0,  32'h12345678, 32'h0,        0, 0, 0, 32'h500, 32'h12345678, 4'b1111, 32'h0);
    vt[8] = mkv(0, FW,  32'h500,      32'h2,  32'h0,        32'h0,        0, 0, 1, 32'h0,   32'h0,        4'h0,    32'h502);
    vt[9] = mkv(0, FBU, 32'h0,        32'h21, 32'h0,        32'h0000F100, 3, 0, 0, 32'h20,  32'h0,        4'h0,    32'h000000F1);

    rst = 1'b0; flush = 1'b0; enq_valid = 1'b0; enq_is_store = 1'b0; enq_tag = '0; enq_funct3 = '0;
    enq_imm = '0; enq_s1_rdy = 1'b0; enq_s2_rdy = 1'b0; enq_s1_tag = '0; enq_s2_tag = '0;
    enq_s1 = '0; enq_s2 = '0; cdb_valid = '0; cdb_tag = '0; cdb_data = '0;
    store_ready = 1'b1; load_ready = 1'b1; mem_rdata = '0; mem_resp = 1'b0;

    #7;
    check("rst_mem_rw", {30'b0, mem_read, mem_write}, 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_data", res_data, 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_enq_ready", 32'(enq_ready), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 10; v++) run_vec(v, vt[v]);

    // CDB capture into a waiting entry: lanes 1 and 2 both match, lane 1 must win.
    enq(0, FW, 5'd20, 32'h4, 1'b0, 5'd7, 32'h0, 1'b1, 5'd0, 32'h0);
    check("cdb_wait_req0", 32'(mem_read), 32'd0);
    @(negedge clk);
    check("cdb_wait_req1", 32'(mem_read), 32'd0);
    cdb_valid = 3'b110;
    cdb_tag   = {5'd7, 5'd7, 5'd7};
    cdb_data  = {32'h20, 32'h10, 32'h99};
    @(negedge clk);
    cdb_valid = '0;
    check("cdb_capture_req", 32'(mem_read), 32'd0);
    @(negedge clk);
    check("cdb_lane_req", 32'(mem_read), 32'd1);
    check("cdb_lane_addr", mem_addr, 32'h14);
    respond_load("cdb_lane", 32'h11112222, 5'd20, 32'h11112222);
    $display("seq cdb_lowest_lane: addr=0x14 res=0x%08h", res_data);

    // Operand snooped from the CDB in the same cycle it is enqueued.
    cdb_valid = 3'b101;
    cdb_tag   = {5'd9, 5'd0, 5'd3};
    cdb_data  = {32'h40, 32'h0, 32'h77};
    enq(0, FW, 5'd21, 32'h0, 1'b0, 5'd9, 32'h0, 1'b1, 5'd0, 32'h0);
    cdb_valid = '0;
    @(negedge clk);
    check("cdb_enq_req", 32'(mem_read), 32'd1);
    check("cdb_enq_addr", mem_addr, 32'h40);
    respond_load("cdb_enq", 32'h0BADF00D, 5'd21, 32'h0BADF00D);
    $display("seq cdb_enq_snoop: addr=0x40 res=0x%08h", res_data);

    // Fill and drain twice so both pointers wrap twice.
    for (int r = 0; r < 2; r++) begin
      load_ready = 1'b0;
      for (int i = 0; i < DEPTH; i++)
        enq(0, FW, 5'(10 + i), 32'(i * 4), 1'b1, 5'd0, 32'h800 + 32'(r * 256), 1'b1, 5'd0, 32'h0);
      check("full_count", 32'(count), 32'(DEPTH));
      check("full_enq_ready", 32'(enq_ready), 32'd0);
      enq_valid = 1'b1;
      @(negedge clk);
      enq_valid = 1'b0;
      check("full_reject_count", 32'(count), 32'(DEPTH));
      load_ready = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
        wait_req("drain_req", got);
        if (got) begin
          check("drain_addr", mem_addr, 32'h800 + 32'(r * 256) + 32'(i * 4));
          if (i == 0) begin
            check("deq_no_free_slot", 32'(enq_ready), 32'd0);
            enq_valid = 1'b1;
          end
          mem_resp = 1'b1; mem_rdata = 32'hA000 + 32'(i);
          @(negedge clk);
          mem_resp = 1'b0; enq_valid = 1'b0;
          check("drain_res_valid", 32'(res_valid), 32'd1);
          check("drain_res_tag", 32'(res_tag), 32'(10 + i));
          check("drain_res_data", res_data, 32'hA000 + 32'(i));
          if (i == 0) check("drain_count_after_deq", 32'(count), 32'(DEPTH - 1));
        end
      end
      @(negedge clk);
      check("drain_empty", 32'(count), 32'd0);
      $display("seq fill_drain round %0d: %0d entries in order", r, DEPTH);
    end

    // Flush while a load is outstanding; the response arrives two cycles later.
    enq(0, FW, 5'd1, 32'h0, 1'b1, 5'd0, 32'h600, 1'b1, 5'd0, 32'h0);
    enq(0, FW, 5'd2, 32'h4, 1'b1, 5'd0, 32'h600, 1'b1, 5'd0, 32'h0);
    wait_req("flush_req", got);
    check("flush_pre_count", 32'(count), 32'd2);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("drain_hold_req", 32'(mem_read), 32'd1);
    check("drain_hold_addr", mem_addr, 32'h600);
    check("drain_enq_ready", 32'(enq_ready), 32'd0);
    check("drain_count", 32'(count), 32'd0);
    @(negedge clk);
    check("drain_hold_req2", 32'(mem_read), 32'd1);
    mem_resp = 1'b1; mem_rdata = 32'h55555555;
    @(negedge clk);
    mem_resp = 1'b0;
    check("drain_req_drop", 32'(mem_read), 32'd0);
    check("drain_no_res", 32'(res_valid), 32'd0);
    @(negedge clk);
    check("drain_no_res2", 32'(res_valid), 32'd0);
    check("drain_idle_ready", 32'(enq_ready), 32'd1);
    check("drain_no_reissue", 32'(mem_read), 32'd0);
    $display("seq flush_during_access: response dropped");

    // Flush coincident with the response.
    enq(0, FW, 5'd3, 32'h0, 1'b1, 5'd0, 32'h700, 1'b1, 5'd0, 32'h0);
    wait_req("flushresp_req", got);
    flush = 1'b1; mem_resp = 1'b1; mem_rdata = 32'h66666666;
    @(negedge clk);
    flush = 1'b0; mem_resp = 1'b0;
    check("flushresp_req_drop", 32'(mem_read), 32'd0);
    check("flushresp_no_res", 32'(res_valid), 32'd0);
    check("flushresp_count", 32'(count), 32'd0);
    check("flushresp_enq_ready", 32'(enq_ready), 32'd1);
    @(negedge clk);
    check("flushresp_no_res2", 32'(res_valid), 32'd0);
    $display("seq flush_with_resp: no result");

    // Flush beats a coincident enqueue.
    flush = 1'b1;
    enq(0, FW, 5'd4, 32'h0, 1'b1, 5'd0, 32'h800, 1'b1, 5'd0, 32'h0);
    flush = 1'b0;
    check("flush_enq_count", 32'(count), 32'd0);
    @(negedge clk);
    check("flush_enq_noreq", 32'(mem_read), 32'd0);
    $display("seq flush_vs_enq: entry dropped");

    run_vec(4, vt[4]);

    // Asynchronous reset in the middle of an access drops the request without a clock edge.
    enq(0, FW, 5'd5, 32'h0, 1'b1, 5'd0, 32'h900, 1'b1, 5'd0, 32'h0);
    wait_req("arst_req", got);
    #2;
    rst = 1'b0;
    #1;
    check("arst_req_drop", 32'(mem_read), 32'd0);
    check("arst_count", 32'(count), 32'd0);
    check("arst_enq_ready", 32'(enq_ready), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    $display("seq async_reset_mid_access: request dropped");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
